// File: rtl/photo_xfer_pkg.sv
// Shared definitions for the photo transfer sequencer.
//   xfer_state_e : top-level sequencer states
//   SdWordW      : SD data word width; pixels are zero-padded up to this
//   calc_nsec    : number of SD sectors needed to hold one photo
package photo_xfer_pkg;

  localparam int unsigned SdWordW = 16;

  typedef enum logic [3:0] {
    StIdle,
    StWrStart,
    StWrWait,
    StWrData,
    StRdStart,
    StRdWait,
    StRdData,
    StDone,
    StErr
  } xfer_state_e;

  function automatic int unsigned calc_nsec(input int unsigned num_pix,
                                            input int unsigned words_per_sec);
    return (num_pix + words_per_sec - 1) / words_per_sec;
  endfunction

endpackage

// File: rtl/sd_sector_stepper.sv
// One SD sector handshake, shared by the write and read directions.
// Issues the start pulse and sector address, tracks the selected sd_ctrl busy
// flag (level and falling edge), counts cycles waiting for busy to rise and
// counts data words for the sector.
//   clk, rst_n            : clock, synchronous active-low reset
//   dir                   : 0 = write (capture), 1 = read (load)
//   launch                : request a sector start at sec_addr
//   sec_addr              : sector address to issue
//   waiting               : sequencer is waiting for busy to rise
//   wr_busy, wr_req       : sd_ctrl write busy / write word request
//   rd_busy, rd_val_en    : sd_ctrl read busy / read word valid
//   wr_start_en, wr_sec_addr, rd_start_en, rd_sec_addr : to sd_ctrl
//   busy_hi, busy_fall    : selected busy level and its falling edge
//   timeout               : busy failed to rise within TIMEOUT cycles
//   cnt_ok                : exactly WORDS_PER_SEC words seen since launch
module sd_sector_stepper #(
  parameter int unsigned WORDS_PER_SEC = 256,
  parameter int unsigned TIMEOUT       = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dir,
  input  logic        launch,
  input  logic [31:0] sec_addr,
  input  logic        waiting,
  input  logic        wr_busy,
  input  logic        wr_req,
  input  logic        rd_busy,
  input  logic        rd_val_en,
  output logic        wr_start_en,
  output logic [31:0] wr_sec_addr,
  output logic        rd_start_en,
  output logic [31:0] rd_sec_addr,
  output logic        busy_hi,
  output logic        busy_fall,
  output logic        timeout,
  output logic        cnt_ok
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  // One extra code so an over-long sector saturates above WORDS_PER_SEC.
  localparam int unsigned CntW = $clog2(WORDS_PER_SEC + 2);

  logic [TmoW-1:0] tmo_cnt_q;
  logic [CntW-1:0] word_cnt_q;
  logic            busy_q;
  logic            word_strobe;

  assign busy_hi     = dir ? rd_busy : wr_busy;
  assign word_strobe = dir ? rd_val_en : wr_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_start_en <= 1'b0;
      rd_start_en <= 1'b0;
      wr_sec_addr <= '0;
      rd_sec_addr <= '0;
      busy_q      <= 1'b0;
      tmo_cnt_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      wr_start_en <= launch & ~dir;
      rd_start_en <= launch & dir;
      if (launch && !dir) wr_sec_addr <= sec_addr;
      if (launch && dir)  rd_sec_addr <= sec_addr;
      busy_q <= busy_hi;

      if (launch) begin
        tmo_cnt_q <= '0;
      end else if (waiting && tmo_cnt_q != TmoW'(TIMEOUT)) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end

      if (launch) begin
        word_cnt_q <= '0;
      end else if (word_strobe && word_cnt_q != CntW'(WORDS_PER_SEC + 1)) begin
        word_cnt_q <= word_cnt_q + 1'b1;
      end
    end
  end

  assign busy_fall = busy_q & ~busy_hi;
  assign timeout   = (tmo_cnt_q == TmoW'(TIMEOUT));
  assign cnt_ok    = (word_cnt_q == CntW'(WORDS_PER_SEC));

endmodule

// File: rtl/photo_xfer_ctrl.sv
// Photo transfer sequencer between the mode controller, frame RAM port B and
// sd_ctrl. Capture streams a photo slot from frame RAM to SD sectors, load
// streams SD sectors back into frame RAM.
//   sys_clk, sys_rst_n        : clock, synchronous active-low reset
//   cap_req, load_req         : one-cycle start pulses (capture wins a tie)
//   slot_no                   : photo slot, sampled on an accepted request
//   sd_init_done              : requests ignored while low
//   wr_start_en, wr_sec_addr, wr_busy, wr_req       : sd_ctrl write side
//   rd_start_en, rd_sec_addr, rd_busy, rd_val_en    : sd_ctrl read side
//   ram_addr, ram_wr_en       : frame RAM port B address / write enable
//   busy, done, err           : transfer status (err is sticky)
module photo_xfer_ctrl
  import photo_xfer_pkg::*;
#(
  parameter int unsigned PIX_W         = 12,
  parameter int unsigned ADDR_W        = 19,
  parameter int unsigned NUM_PIX       = 307200,
  parameter int unsigned WORDS_PER_SEC = 256,
  parameter int unsigned SLOT_BITS     = 4,
  parameter int unsigned NUM_SLOTS     = 16,
  parameter logic [31:0] SEC_BASE      = 32'd16384,
  parameter int unsigned SLOT_STRIDE   = 1280,
  parameter int unsigned TIMEOUT       = 65535
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 cap_req,
  input  logic                 load_req,
  input  logic [SLOT_BITS-1:0] slot_no,
  input  logic                 sd_init_done,
  output logic                 wr_start_en,
  output logic [31:0]          wr_sec_addr,
  input  logic                 wr_busy,
  input  logic                 wr_req,
  output logic                 rd_start_en,
  output logic [31:0]          rd_sec_addr,
  input  logic                 rd_busy,
  input  logic                 rd_val_en,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_wr_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned NSEC = calc_nsec(NUM_PIX, WORDS_PER_SEC);
  localparam int unsigned SecW = $clog2(NSEC + 1);
  localparam logic [ADDR_W-1:0] LastPix = ADDR_W'(NUM_PIX - 1);

  if (PIX_W > SdWordW) begin : g_pix_w_chk
    $error("PIX_W must not exceed the SD word width");
  end
  if (SLOT_STRIDE < NSEC) begin : g_stride_chk
    $error("SLOT_STRIDE is smaller than the sectors needed per photo");
  end

  xfer_state_e          state_q, state_d;
  logic [SLOT_BITS-1:0] slot_q;
  logic [SecW-1:0]      sec_cnt_q;
  logic                 dir_q;       // 1 = load
  logic                 rd_full_q;   // every pixel of the photo has been written

  logic        req_ok, slot_bad, launch, waiting, last_sec;
  logic        busy_hi, busy_fall, timeout, cnt_ok;
  logic        wr_phase, rd_phase;
  logic [31:0] sec_addr;

  assign req_ok   = sd_init_done & (cap_req | load_req);
  assign slot_bad = (32'(slot_no) >= 32'(NUM_SLOTS));
  assign waiting  = (state_q == StWrWait) || (state_q == StRdWait);
  assign last_sec = (sec_cnt_q == SecW'(NSEC - 1));
  assign sec_addr = SEC_BASE + 32'(slot_q) * SLOT_STRIDE + 32'(sec_cnt_q);

  // A word may arrive in the same cycle busy rises, before the FSM has
  // stepped into the data state; treat that cycle as data too.
  assign wr_phase = (state_q == StWrData) || (state_q == StWrWait && wr_busy);
  assign rd_phase = (state_q == StRdData) || (state_q == StRdWait && rd_busy);

  assign ram_wr_en = rd_phase & rd_val_en & ~rd_full_q;
  assign done      = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_ok && !slot_bad) state_d = cap_req ? StWrStart : StRdStart;
      end
      StWrStart: begin
        launch  = 1'b1;
        state_d = StWrWait;
      end
      StWrWait: begin
        if (busy_hi)      state_d = StWrData;
        else if (timeout) state_d = StErr;
      end
      StWrData: begin
        if (busy_fall) state_d = !cnt_ok ? StErr : (last_sec ? StDone : StWrStart);
      end
      StRdStart: begin
        launch  = 1'b1;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (busy_hi)      state_d = StRdData;
        else if (timeout) state_d = StErr;
      end
      StRdData: begin
        if (busy_fall) state_d = !cnt_ok ? StErr : (last_sec ? StDone : StRdStart);
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      slot_q    <= '0;
      sec_cnt_q <= '0;
      dir_q     <= 1'b0;
      rd_full_q <= 1'b0;
      ram_addr  <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == StIdle && req_ok) begin
        if (slot_bad) begin
          err <= 1'b1;
        end else begin
          slot_q    <= slot_no;
          dir_q     <= ~cap_req;
          sec_cnt_q <= '0;
          rd_full_q <= 1'b0;
          ram_addr  <= '0;
          err       <= 1'b0;
          busy      <= 1'b1;
        end
      end

      if ((state_q == StWrData || state_q == StRdData) && busy_fall && cnt_ok) begin
        sec_cnt_q <= sec_cnt_q + 1'b1;
      end

      // Capture pre-fetches one address ahead; padding words re-read the last pixel.
      if (wr_phase && wr_req && ram_addr != LastPix) begin
        ram_addr <= ram_addr + 1'b1;
      end

      if (ram_wr_en) begin
        if (ram_addr == LastPix) rd_full_q <= 1'b1;
        else                     ram_addr  <= ram_addr + 1'b1;
      end

      if (state_q == StDone) busy <= 1'b0;
      if (state_q == StErr) begin
        err  <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

  sd_sector_stepper #(
    .WORDS_PER_SEC (WORDS_PER_SEC),
    .TIMEOUT       (TIMEOUT)
  ) u_stepper (
    .clk         (sys_clk),
    .rst_n       (sys_rst_n),
    .dir         (dir_q),
    .launch      (launch),
    .sec_addr    (sec_addr),
    .waiting     (waiting),
    .wr_busy     (wr_busy),
    .wr_req      (wr_req),
    .rd_busy     (rd_busy),
    .rd_val_en   (rd_val_en),
    .wr_start_en (wr_start_en),
    .wr_sec_addr (wr_sec_addr),
    .rd_start_en (rd_start_en),
    .rd_sec_addr (rd_sec_addr),
    .busy_hi     (busy_hi),
    .busy_fall   (busy_fall),
    .timeout     (timeout),
    .cnt_ok      (cnt_ok)
  );

endmodule

// File: tb/tb_photo_xfer_ctrl.sv
// Self-checking bench for photo_xfer_ctrl with small photo parameters, a
// randomized sd_ctrl responder and a transaction-level reference model.
module tb_photo_xfer_ctrl;

  localparam int NumPix   = 600;
  localparam int Wps      = 256;
  localparam int Stride   = 4;
  localparam int SecBase  = 100;
  localparam int NumSlots = 12;
  localparam int Tmo      = 20;
  localparam int AddrW    = 10;
  localparam int SlotBits = 4;
  localparam int Nsec     = (NumPix + Wps - 1) / Wps;

  logic                sys_clk = 1'b0;
  logic                sys_rst_n;
  logic                cap_req, load_req, sd_init_done;
  logic [SlotBits-1:0] slot_no;
  logic                wr_start_en, rd_start_en, wr_busy, wr_req, rd_busy, rd_val_en;
  logic [31:0]         wr_sec_addr, rd_sec_addr;
  logic [AddrW-1:0]    ram_addr;
  logic                ram_wr_en, busy, done, err;

  photo_xfer_ctrl #(
    .PIX_W         (12),
    .ADDR_W        (AddrW),
    .NUM_PIX       (NumPix),
    .WORDS_PER_SEC (Wps),
    .SLOT_BITS     (SlotBits),
    .NUM_SLOTS     (NumSlots),
    .SEC_BASE      (32'(SecBase)),
    .SLOT_STRIDE   (Stride),
    .TIMEOUT       (Tmo)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .cap_req      (cap_req),
    .load_req     (load_req),
    .slot_no      (slot_no),
    .sd_init_done (sd_init_done),
    .wr_start_en  (wr_start_en),
    .wr_sec_addr  (wr_sec_addr),
    .wr_busy      (wr_busy),
    .wr_req       (wr_req),
    .rd_start_en  (rd_start_en),
    .rd_sec_addr  (rd_sec_addr),
    .rd_busy      (rd_busy),
    .rd_val_en    (rd_val_en),
    .ram_addr     (ram_addr),
    .ram_wr_en    (ram_wr_en),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Observed transactions, sampled on the falling edge.
  int unsigned mon_wr_starts[$];
  int unsigned mon_rd_starts[$];
  int          mon_done, mon_wr, mon_wr_bad, mon_max_addr;
  bit          mon_clr = 1'b0;

  always @(negedge sys_clk) begin
    if (mon_clr) begin
      mon_wr_starts.delete();
      mon_rd_starts.delete();
      mon_done     = 0;
      mon_wr       = 0;
      mon_wr_bad   = 0;
      mon_max_addr = 0;
    end else begin
      if (wr_start_en) mon_wr_starts.push_back(wr_sec_addr);
      if (rd_start_en) mon_rd_starts.push_back(rd_sec_addr);
      if (done) mon_done++;
      if (ram_wr_en) begin
        if (int'(ram_addr) != mon_wr) mon_wr_bad++;
        mon_wr++;
      end
      if (int'(ram_addr) > mon_max_addr) mon_max_addr = int'(ram_addr);
    end
  end

  task automatic mon_reset();
    mon_clr = 1'b1;
    @(negedge sys_clk);
    #1 mon_clr = 1'b0;
  endtask

  // sd_ctrl responder: random busy latency and random gaps between words.
  int sd_words   = Wps;
  bit sd_no_busy = 1'b0;
  bit sd_active  = 1'b0;

  task automatic sd_xfer(input bit is_rd);
    sd_active = 1'b1;
    repeat ($urandom_range(1, 4)) @(posedge sys_clk);
    #1;
    if (is_rd) rd_busy = 1'b1;
    else       wr_busy = 1'b1;
    for (int i = 0; i < sd_words; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge sys_clk);
      #1;
      if (is_rd) rd_val_en = 1'b1;
      else       wr_req    = 1'b1;
      @(posedge sys_clk);
      #1;
      rd_val_en = 1'b0;
      wr_req    = 1'b0;
    end
    repeat (2) @(posedge sys_clk);
    #1;
    rd_busy = 1'b0;
    wr_busy = 1'b0;
    @(posedge sys_clk);
    #1 sd_active = 1'b0;
  endtask

  initial begin
    wr_busy = 1'b0; rd_busy = 1'b0; wr_req = 1'b0; rd_val_en = 1'b0;
    forever begin
      @(negedge sys_clk);
      if ((wr_start_en || rd_start_en) && !sd_no_busy) sd_xfer(rd_start_en);
    end
  end

  task automatic pulse_req(input bit cap, input bit load, input int slot);
    @(posedge sys_clk);
    #1;
    cap_req  = cap;
    load_req = load;
    slot_no  = SlotBits'(slot);
    @(posedge sys_clk);
    #1;
    cap_req  = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (busy && n < budget);
    check_eq({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic wait_sd(input string tag, input int budget);
    int n = 0;
    while (sd_active && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq({tag, "_sd_quiet"}, 32'(sd_active), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_wr_start"}, 32'(wr_start_en), 0);
    check_eq({tag, "_wr_addr"},  wr_sec_addr, 0);
    check_eq({tag, "_rd_start"}, 32'(rd_start_en), 0);
    check_eq({tag, "_rd_addr"},  rd_sec_addr, 0);
    check_eq({tag, "_ram_addr"}, 32'(ram_addr), 0);
    check_eq({tag, "_ram_we"},   32'(ram_wr_en), 0);
    check_eq({tag, "_busy"},     32'(busy), 0);
    check_eq({tag, "_done"},     32'(done), 0);
    check_eq({tag, "_err"},      32'(err), 0);
  endtask

  // Full transfer against the reference: Nsec sectors at consecutive
  // addresses from the slot base, one done, no error; capture leaves the RAM
  // pointer at min(words requested, NumPix-1), load writes pixels 0..NumPix-1.
  task automatic run_xfer(input string tag, input bit cap, input bit load, input int slot);
    int unsigned starts[$];
    int          other;
    mon_reset();
    pulse_req(cap, load, slot);
    wait_idle(tag, 6000);
    wait_sd(tag, 200);
    if (cap) begin
      starts = mon_wr_starts;
      other  = mon_rd_starts.size();
    end else begin
      starts = mon_rd_starts;
      other  = mon_wr_starts.size();
    end
    check_eq({tag, "_nsec"}, starts.size(), Nsec);
    for (int k = 0; k < starts.size() && k < Nsec; k++) begin
      check_eq({tag, "_sec_addr"}, starts[k], SecBase + slot * Stride + k);
    end
    check_eq({tag, "_other_dir"}, other, 0);
    check_eq({tag, "_done_cnt"}, mon_done, 1);
    check_eq({tag, "_err"}, 32'(err), 0);
    if (cap) begin
      check_eq({tag, "_ram_end"}, 32'(ram_addr),
               (Nsec * Wps < NumPix - 1) ? Nsec * Wps : NumPix - 1);
      check_eq({tag, "_ram_max"}, mon_max_addr, NumPix - 1);
      check_eq({tag, "_no_ram_we"}, mon_wr, 0);
    end else begin
      check_eq({tag, "_ram_we_cnt"}, mon_wr, NumPix);
      check_eq({tag, "_ram_we_order"}, mon_wr_bad, 0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int slot, n;
    bit cap;
    sys_rst_n = 1'b0; cap_req = 1'b0; load_req = 1'b0; slot_no = '0; sd_init_done = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_outputs_zero("reset");
    @(posedge sys_clk);
    #1;
    sys_rst_n    = 1'b1;
    sd_init_done = 1'b1;
    repeat (2) @(posedge sys_clk);

    run_xfer("cap_s2", 1'b1, 1'b0, 2);
    run_xfer("load_s1", 1'b0, 1'b1, 1);
    run_xfer("both_s0", 1'b1, 1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      cap  = 1'($urandom_range(0, 1));
      slot = int'($urandom_range(0, NumSlots - 1));
      run_xfer(cap ? "rnd_cap" : "rnd_load", cap, !cap, slot);
    end

    // Request while the card is not initialised: ignored, err untouched.
    sd_init_done = 1'b0;
    mon_reset();
    pulse_req(1'b1, 1'b0, 3);
    repeat (5) @(negedge sys_clk);
    check_eq("noinit_busy", 32'(busy), 0);
    check_eq("noinit_err", 32'(err), 0);
    check_eq("noinit_starts", mon_wr_starts.size() + mon_rd_starts.size(), 0);
    sd_init_done = 1'b1;

    // Out-of-range slot: err only.
    mon_reset();
    pulse_req(1'b0, 1'b1, int'($urandom_range(NumSlots, 15)));
    repeat (5) @(negedge sys_clk);
    check_eq("badslot_busy", 32'(busy), 0);
    check_eq("badslot_err", 32'(err), 1);
    check_eq("badslot_starts", mon_wr_starts.size() + mon_rd_starts.size(), 0);
    run_xfer("after_bad", 1'b0, 1'b1, 4);

    // busy never rises: still busy well into the window, then err.
    sd_no_busy = 1'b1;
    mon_reset();
    pulse_req(1'b1, 1'b0, 5);
    repeat (Tmo - 2) @(negedge sys_clk);
    check_eq("tmo_still_busy", 32'(busy), 1);
    wait_idle("tmo", 15);
    check_eq("tmo_err", 32'(err), 1);
    check_eq("tmo_done", mon_done, 0);
    check_eq("tmo_starts", mon_wr_starts.size(), 1);
    sd_no_busy = 1'b0;

    // One word short in the first sector.
    sd_words = Wps - 1;
    mon_reset();
    pulse_req(1'b1, 1'b0, 7);
    wait_idle("short", 3000);
    check_eq("short_err", 32'(err), 1);
    check_eq("short_done", mon_done, 0);
    check_eq("short_starts", mon_wr_starts.size(), 1);
    wait_sd("short", 200);
    sd_words = Wps;

    // Reset in the middle of the second sector of a load.
    slot = int'($urandom_range(0, NumSlots - 1));
    mon_reset();
    pulse_req(1'b0, 1'b1, slot);
    n = 0;
    while (mon_rd_starts.size() < 2 && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq("rst_reach_sec2", mon_rd_starts.size(), 2);
    repeat (40) @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_outputs_zero("midrst");
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    mon_reset();
    wait_sd("midrst", 2000);
    repeat (3) @(negedge sys_clk);
    check_eq("midrst_ignored_we", mon_wr, 0);
    check_eq("midrst_ignored_busy", 32'(busy), 0);
    run_xfer("load_after_rst", 1'b0, 1'b1, slot);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
